// File: rtl/time_display_driver.sv
// time_display_driver
// Converts the countdown timer's binary seconds value to two BCD digits with a
// sequential shift-and-add-3 engine. It drives two active-low seven-segment
// digits and blinks them while the game is stopped.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   ms100     in   single-cycle 100 ms tick
//   time_in   in   [6:0] remaining seconds (0..127)
//   stop_in   in   stop flag; blinks the display while high
//   bcd_tens  out  [3:0] registered tens digit
//   bcd_ones  out  [3:0] registered ones digit
//   seg_tens  out  [6:0] tens segments, active-low {g,f,e,d,c,b,a}
//   seg_ones  out  [6:0] ones segments, active-low {g,f,e,d,c,b,a}
//   valid     out  one-cycle pulse when new digits are loaded
//   overflow  out  high while the shown value was clamped from time_in > 99
//
// state | meaning
// IDLE  | waiting for a forced conversion or a change of time_in
// SHIFT | double-dabble, one bit per clock, 7 clocks
// DONE  | load digits, pulse valid
module time_display_driver #(
  parameter int BLINK_TICKS   = 5,
  parameter bit LEADING_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ms100,
  input  logic [6:0] time_in,
  input  logic       stop_in,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       valid,
  output logic       overflow
);

  localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [6:0]      r_last_val;
  logic            r_pending;
  logic [6:0]      r_bin;
  logic [7:0]      r_scratch;
  logic [2:0]      r_iter;
  logic            r_ovf_tmp;
  logic [3:0]      r_bcd_tens;
  logic [3:0]      r_bcd_ones;
  logic            r_valid;
  logic            r_overflow;
  logic [CW-1:0]   r_blink_cnt;
  logic            r_blank_phase;

  logic            w_capture;
  logic            w_last_shift;
  logic [6:0]      w_clamped;
  logic [3:0]      w_adj_tens;
  logic [3:0]      w_adj_ones;

  assign w_capture    = (r_state == IDLE) && (r_pending || (time_in != r_last_val));
  assign w_last_shift = (r_iter == 3'd6);
  assign w_clamped    = (time_in > 7'd99) ? 7'd99 : time_in;
  assign w_adj_tens   = (r_scratch[7:4] >= 4'd5) ? r_scratch[7:4] + 4'd3 : r_scratch[7:4];
  assign w_adj_ones   = (r_scratch[3:0] >= 4'd5) ? r_scratch[3:0] + 4'd3 : r_scratch[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_next = SHIFT;
      SHIFT:   if (w_last_shift) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_val <= 7'd0;
      r_pending  <= 1'b1;
      r_bin      <= 7'd0;
      r_scratch  <= 8'd0;
      r_iter     <= 3'd0;
      r_ovf_tmp  <= 1'b0;
      r_bcd_tens <= 4'd0;
      r_bcd_ones <= 4'd0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_last_val <= time_in;
            r_pending  <= 1'b0;
            r_bin      <= w_clamped;
            r_ovf_tmp  <= (time_in > 7'd99);
            r_scratch  <= 8'd0;
            r_iter     <= 3'd0;
          end
        end
        SHIFT: begin
          // The tens nibble never exceeds 9 for inputs <= 99, so its carry-out
          // bit is always zero and can be dropped.
          {r_scratch, r_bin} <= {w_adj_tens[2:0], w_adj_ones, r_bin, 1'b0};
          r_iter             <= r_iter + 3'd1;
        end
        DONE: begin
          r_bcd_tens <= r_scratch[7:4];
          r_bcd_ones <= r_scratch[3:0];
          r_overflow <= r_ovf_tmp;
          r_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blank_phase <= 1'b0;
    end else if (!stop_in) begin
      r_blink_cnt   <= '0;
      r_blank_phase <= 1'b0;
    end else if (ms100) begin
      if (r_blink_cnt == CW'(BLINK_TICKS - 1)) begin
        r_blink_cnt   <= '0;
        r_blank_phase <= ~r_blank_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    seg_tens = seg7(r_bcd_tens);
    seg_ones = seg7(r_bcd_ones);
    if (LEADING_BLANK && (r_bcd_tens == 4'd0)) seg_tens = 7'b1111111;
    if (r_blank_phase) begin
      seg_tens = 7'b1111111;
      seg_ones = 7'b1111111;
    end
  end

  assign bcd_tens = r_bcd_tens;
  assign bcd_ones = r_bcd_ones;
  assign valid    = r_valid;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_time_display_driver.sv
// tb_time_display_driver
// Directed and randomized stimulus against a cycle-level reference model that
// computes digits arithmetically (value / 10, value % 10) and tracks conversion
// latency as a countdown.
module tb_time_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       ms100;
  logic [6:0] time_in;
  logic       stop_in;
  logic [3:0] bcd_tens, bcd_ones;
  logic [6:0] seg_tens, seg_ones;
  logic       valid, overflow;

  int checks   = 0;
  int failures = 0;

  time_display_driver #(.BLINK_TICKS(5), .LEADING_BLANK(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .ms100    (ms100),
    .time_in  (time_in),
    .stop_in  (stop_in),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .seg_tens (seg_tens),
    .seg_ones (seg_ones),
    .valid    (valid),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_lut [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  // reference model state
  int m_busy, m_last, m_cap, m_tens, m_ones, m_cnt;
  bit m_pending, m_ovf, m_valid, m_ph;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_last = 0; m_cap = 0; m_tens = 0; m_ones = 0; m_cnt = 0;
      m_pending = 1; m_ovf = 0; m_valid = 0; m_ph = 0;
    end else begin
      m_valid = 0;
      if (!stop_in) begin
        m_cnt = 0; m_ph = 0;
      end else if (ms100) begin
        m_cnt++;
        if (m_cnt == 5) begin m_cnt = 0; m_ph = !m_ph; end
      end
      if (m_busy == 0) begin
        if (m_pending || (int'(time_in) != m_last)) begin
          m_last = int'(time_in); m_cap = int'(time_in); m_pending = 0; m_busy = 8;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_ovf   = (m_cap > 99);
          m_tens  = ((m_cap > 99) ? 99 : m_cap) / 10;
          m_ones  = ((m_cap > 99) ? 99 : m_cap) % 10;
          m_valid = 1;
        end
      end
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int e_tens, e_ones;
    e_ones = m_ph ? 7'h7f : int'(seg_lut[m_ones]);
    e_tens = (m_ph || m_tens == 0) ? 7'h7f : int'(seg_lut[m_tens]);
    check_val("bcd_tens", int'(bcd_tens), m_tens);
    check_val("bcd_ones", int'(bcd_ones), m_ones);
    check_val("valid",    int'(valid),    int'(m_valid));
    check_val("overflow", int'(overflow), int'(m_ovf));
    check_val("seg_tens", int'(seg_tens), e_tens);
    check_val("seg_ones", int'(seg_ones), e_ones);
  endtask

  int cyc = 0;
  int ms_period = 0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
      cyc++;
      ms100 = (ms_period > 0) && (cyc % ms_period == 0);
    end
  endtask

  int vcount;
  bit reached;

  initial begin
    rst = 1'b1; ms100 = 1'b0; time_in = 7'd0; stop_in = 1'b0;
    #1;
    check_val("rst_seg_ones", int'(seg_ones), 7'b1000000);
    check_val("rst_seg_tens", int'(seg_tens), 7'b1111111);
    check_val("rst_valid",    int'(valid),    0);
    step(3);
    rst = 1'b0;
    step(20);

    time_in = 7'd30;  step(15);
    time_in = 7'd7;   step(15);
    time_in = 7'd120; step(15);
    time_in = 7'd45;  step(15);

    // change during conversion: two valid pulses
    time_in = 7'd30; step(3);
    time_in = 7'd29;
    vcount = 0;
    for (int i = 0; i < 30; i++) begin step(1); if (valid) vcount++; end
    check_val("two_valid_pulses", vcount, 2);

    // blink with ms100 every 10 clocks
    stop_in = 1'b1; ms_period = 10;
    step(120);
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin step(1); reached = m_ph; end
    check_val("blink_reached", int'(reached), 1);
    stop_in = 1'b0;
    step(5);
    ms_period = 0; ms100 = 1'b0;

    // reset during SHIFT
    time_in = 7'd55; step(3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_bcd_tens", int'(bcd_tens), 0);
    check_val("midrst_bcd_ones", int'(bcd_ones), 0);
    check_val("midrst_valid",    int'(valid),    0);
    check_val("midrst_seg_ones", int'(seg_ones), 7'b1000000);
    step(2);
    rst = 1'b0;
    step(20);

    // randomized
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if ($urandom_range(7) == 0) time_in = 7'($urandom_range(127));
      if ($urandom_range(49) == 0) stop_in = ~stop_in;
      ms100 = ($urandom_range(3) == 0);
    end
    stop_in = 1'b0; ms100 = 1'b0;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
